// File: rtl/test_supervisor.sv
// Self-test supervisor: folds per-unit error/done flags into one sticky verdict
// with a RUN-cycle counter and a watchdog timeout.

module test_supervisor_lane (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic capture,
  input  logic result_in,
  input  logic done_in,
  output logic fail_bit,
  output logic done_bit,
  output logic fail_next,
  output logic done_next
);
  // Look-ahead values let the top decide the verdict on the same edge that
  // samples the last flag.
  assign fail_next = fail_bit | result_in;
  assign done_next = done_bit | done_in;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fail_bit <= 1'b0;
      done_bit <= 1'b0;
    end else if (capture) begin
      fail_bit <= fail_next;
      done_bit <= done_next;
    end
  end
endmodule

module test_supervisor #(
  parameter int N_TESTS        = 2,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_TESTS-1:0] test_result,
  input  logic [N_TESTS-1:0] test_done,
  output logic               done,
  output logic               pass,
  output logic               timed_out,
  output logic [N_TESTS-1:0] fail_mask,
  output logic [N_TESTS-1:0] done_mask,
  output logic [CNT_W-1:0]   cycle_count
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] FINISHED = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]         state;
  logic [N_TESTS-1:0] fail_next;
  logic [N_TESTS-1:0] done_next;
  logic               clear;
  logic               capture;
  logic               all_done;
  logic               any_fail;

  // Start is honoured only outside RUN; a mid-run start must not wipe the masks.
  assign clear    = start && (state != RUN);
  assign capture  = (state == RUN);
  assign all_done = &done_next;
  assign any_fail = |fail_next;

  genvar i;
  generate
    for (i = 0; i < N_TESTS; i++) begin : g_lane
      test_supervisor_lane u_lane (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .capture   (capture),
        .result_in (test_result[i]),
        .done_in   (test_done[i]),
        .fail_bit  (fail_mask[i]),
        .done_bit  (done_mask[i]),
        .fail_next (fail_next[i]),
        .done_next (done_next[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, FINISHED: begin
          if (start) begin
            state       <= RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
          end
        end
        RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          // Completion is checked first so a last done on the timeout cycle still passes.
          if (all_done) begin
            state     <= FINISHED;
            done      <= 1'b1;
            pass      <= ~any_fail;
            timed_out <= 1'b0;
          end else if (cycle_count == LAST_CYCLE) begin
            state     <= FINISHED;
            done      <= 1'b1;
            pass      <= 1'b0;
            timed_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_test_supervisor.sv
// Directed vector table for test_supervisor: each record is one cycle of inputs
// and the outputs expected just after the following rising edge.

module tb_test_supervisor;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  test_result;
  logic [1:0]  test_done;
  logic        done;
  logic        pass;
  logic        timed_out;
  logic [1:0]  fail_mask;
  logic [1:0]  done_mask;
  logic [15:0] cycle_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        start;
    logic [1:0]  res;
    logic [1:0]  dn;
    logic        e_done;
    logic        e_pass;
    logic        e_to;
    logic [1:0]  e_fail;
    logic [1:0]  e_dmask;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs[$];

  test_supervisor #(
    .N_TESTS(2), .TIMEOUT_CYCLES(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .test_result(test_result), .test_done(test_done),
    .done(done), .pass(pass), .timed_out(timed_out),
    .fail_mask(fail_mask), .done_mask(done_mask), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic [1:0] res,
                     input logic [1:0] dn, input logic ed, input logic ep,
                     input logic et, input logic [1:0] ef, input logic [1:0] edm,
                     input int ec);
    vec_t v;
    v.rst = r; v.start = s; v.res = res; v.dn = dn;
    v.e_done = ed; v.e_pass = ep; v.e_to = et;
    v.e_fail = ef; v.e_dmask = edm; v.e_count = 16'(ec);
    vecs.push_back(v);
  endtask

  task automatic chk(input int idx, input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL vec%0d %s: got %0h expected %0h", idx, name, act, exp);
    end
  endtask

  initial begin
    // 1: reset, then idle with inputs toggling (ignored)
    add(1, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    add(1, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    for (int k = 0; k < 20; k++)
      add(0, 0, 2'b11, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0);

    // 2: done[0] at cycle 3, done[1] at cycle 7 -> pass, count 8
    add(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    for (int k = 0; k < 7; k++)
      add(0, 0, 2'b00, (k == 3) ? 2'b01 : 2'b00, 0, 0, 0, 2'b00,
          (k >= 3) ? 2'b01 : 2'b00, k + 1);
    add(0, 0, 2'b00, 2'b10, 1, 1, 0, 2'b00, 2'b11, 8);
    // FINISHED holds against new inputs
    add(0, 0, 2'b11, 2'b11, 1, 1, 0, 2'b00, 2'b11, 8);
    add(0, 0, 2'b11, 2'b00, 1, 1, 0, 2'b00, 2'b11, 8);

    // 3: restart; error on test 1 at cycle 2; start at cycle 3 ignored; both done at 5
    add(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1);
    add(0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2);
    add(0, 0, 2'b10, 2'b00, 0, 0, 0, 2'b10, 2'b00, 3);
    add(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b10, 2'b00, 4);
    add(0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b10, 2'b00, 5);
    add(0, 0, 2'b00, 2'b11, 1, 0, 0, 2'b10, 2'b11, 6);

    // 4: only test 0 done (level) -> timeout after 16 cycles
    add(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    for (int k = 0; k < 15; k++)
      add(0, 0, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b01, k + 1);
    add(0, 0, 2'b00, 2'b01, 1, 0, 1, 2'b00, 2'b01, 16);
    add(0, 0, 2'b00, 2'b11, 1, 0, 1, 2'b00, 2'b01, 16);

    // 5: last done exactly on the timeout cycle -> pass, no timeout
    add(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 0, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b01, 1);
    for (int k = 1; k < 15; k++)
      add(0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b01, k + 1);
    add(0, 0, 2'b00, 2'b10, 1, 1, 0, 2'b00, 2'b11, 16);

    // 6: reset mid-run (with start high) clears everything; then a fresh run
    add(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1);
    add(0, 0, 2'b01, 2'b00, 0, 0, 0, 2'b01, 2'b00, 2);
    add(0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 3);
    add(0, 0, 2'b00, 2'b00, 0, 0, 0, 2'b01, 2'b00, 4);
    add(1, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 0, 2'b11, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 0, 2'b00, 2'b11, 1, 1, 0, 2'b00, 2'b11, 1);

    // 7: late error on a test already done still fails the run
    add(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 0, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b01, 1);
    add(0, 0, 2'b01, 2'b00, 0, 0, 0, 2'b01, 2'b01, 2);
    add(0, 0, 2'b00, 2'b10, 1, 0, 0, 2'b01, 2'b11, 3);

    // 8: error arriving on the same cycle as the final done
    add(0, 1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
    add(0, 0, 2'b10, 2'b11, 1, 0, 0, 2'b10, 2'b11, 1);

    rst = 1'b1; start = 1'b0; test_result = '0; test_done = '0;
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst         = vecs[i].rst;
      start       = vecs[i].start;
      test_result = vecs[i].res;
      test_done   = vecs[i].dn;
      @(posedge clk);
      #1;
      chk(i, "done",        16'(done),        16'(vecs[i].e_done));
      chk(i, "pass",        16'(pass),        16'(vecs[i].e_pass));
      chk(i, "timed_out",   16'(timed_out),   16'(vecs[i].e_to));
      chk(i, "fail_mask",   16'(fail_mask),   16'(vecs[i].e_fail));
      chk(i, "done_mask",   16'(done_mask),   16'(vecs[i].e_dmask));
      chk(i, "cycle_count", cycle_count,      vecs[i].e_count);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
